// File: rtl/done_tracker_pkg.sv
// Shared constants and width helpers for the block-completion tracker.
// No logic, so no latency and no backpressure.
package done_tracker_pkg;

   localparam int unsigned NUM_STREAMS_DEF     = 2;
   localparam int unsigned MAX_OUTSTANDING_DEF = 4;

   // Width of a counter that must hold every value 0..max_val inclusive.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth <= 1) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/done_tracker_if.sv
// Block-start / last-beat / done bundle between the encoder handshake logic and the tracker.
// Outputs are registered-state decodes; blk_ready_o is the only backpressure.
interface done_tracker_if
   import done_tracker_pkg::*;
#(
   parameter int unsigned NUM_STREAMS     = NUM_STREAMS_DEF,
   parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
);

   localparam int unsigned CW = cnt_width(MAX_OUTSTANDING);

   logic                   blk_start_i;
   logic [NUM_STREAMS-1:0] blk_mask_i;
   logic                   blk_ready_o;
   logic [NUM_STREAMS-1:0] last_hs_i;
   logic                   blk_done_o;
   logic [NUM_STREAMS-1:0] blk_done_mask_o;
   logic [CW-1:0]          outstanding_o;
   logic                   err_o;

   modport master (
      output blk_start_i,
      output blk_mask_i,
      output last_hs_i,
      input  blk_ready_o,
      input  blk_done_o,
      input  blk_done_mask_o,
      input  outstanding_o,
      input  err_o
   );

   modport slave (
      input  blk_start_i,
      input  blk_mask_i,
      input  last_hs_i,
      output blk_ready_o,
      output blk_done_o,
      output blk_done_mask_o,
      output outstanding_o,
      output err_o
   );

endinterface

// File: rtl/done_mask_fifo.sv
// Synchronous FIFO holding one stream mask per in-flight block; data visible at head one cycle after push.
// Pushes while full and pops while empty are ignored; the owner gates them with full/empty.
module done_mask_fifo
   import done_tracker_pkg::*;
#(
   parameter int unsigned DEPTH = MAX_OUTSTANDING_DEF,
   parameter int unsigned WIDTH = NUM_STREAMS_DEF
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic                               clr_i,
   input  logic                               push_i,
   input  logic [WIDTH-1:0]                   wdata_i,
   input  logic                               pop_i,
   output logic [WIDTH-1:0]                   rdata_o,
   output logic                               full_o,
   output logic                               empty_o,
   output logic [cnt_width(DEPTH)-1:0]        level_o
);

   localparam int unsigned PW = ptr_width(DEPTH);
   localparam int unsigned LW = cnt_width(DEPTH);

   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [LW-1:0]    level_q;
   logic             do_push;
   logic             do_pop;

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PW'(1);
   endfunction

   assign full_o  = (level_q == LVL_FULL);
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign rdata_o = mem_q[rd_ptr_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_ff @(posedge clk_i) begin
      if (!rst_ni || clr_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (do_pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         case ({do_push, do_pop})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: level_q <= level_q;
         endcase
      end
   end

endmodule

// File: rtl/done_tracker.sv
// Pulses blk_done_o in acceptance order once every masked stream of the head block has a pending last beat.
// Done appears one cycle after the final last beat; blk_ready_o drops while MAX_OUTSTANDING blocks are in flight.
module done_tracker
   import done_tracker_pkg::*;
#(
   parameter int unsigned NUM_STREAMS     = NUM_STREAMS_DEF,
   parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          clr_i,
   done_tracker_if.slave bus
);

   localparam int unsigned   CW      = cnt_width(MAX_OUTSTANDING);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

   logic [NUM_STREAMS-1:0] head;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [CW-1:0]          fifo_level;
   logic                   push;
   logic                   drop;
   logic                   done;
   logic [NUM_STREAMS-1:0] dec;
   logic [NUM_STREAMS-1:0] ovf;
   logic [CW-1:0]          cnt_q [NUM_STREAMS];
   logic [CW-1:0]          cnt_d [NUM_STREAMS];
   logic                   err_q;

   assign push = bus.blk_start_i && !fifo_full;
   assign drop = bus.blk_start_i && fifo_full;

   done_mask_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .WIDTH (NUM_STREAMS)
   ) u_mask_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clr_i   (clr_i),
      .push_i  (push),
      .wdata_i (bus.blk_mask_i),
      .pop_i   (done),
      .rdata_o (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   // Decoded purely from the FIFO head and registered counts, so no input reaches blk_done_o.
   always_comb begin
      done = !fifo_empty;
      for (int n = 0; n < int'(NUM_STREAMS); n++) begin
         if (head[n] && (cnt_q[n] == '0)) begin
            done = 1'b0;
         end
      end
   end

   assign dec = done ? head : '0;

   // A last arriving on a stream that is also being consumed cancels out, so it can never overflow.
   always_comb begin
      ovf = '0;
      for (int n = 0; n < int'(NUM_STREAMS); n++) begin
         cnt_d[n] = cnt_q[n];
         if (bus.last_hs_i[n] && !dec[n]) begin
            if (cnt_q[n] == CNT_MAX) begin
               ovf[n] = 1'b1;
            end else begin
               cnt_d[n] = cnt_q[n] + CW'(1);
            end
         end else if (!bus.last_hs_i[n] && dec[n]) begin
            cnt_d[n] = cnt_q[n] - CW'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni || clr_i) begin
         err_q <= 1'b0;
         for (int n = 0; n < int'(NUM_STREAMS); n++) begin
            cnt_q[n] <= '0;
         end
      end else begin
         if (drop || (|ovf)) begin
            err_q <= 1'b1;
         end
         for (int n = 0; n < int'(NUM_STREAMS); n++) begin
            cnt_q[n] <= cnt_d[n];
         end
      end
   end

   assign bus.blk_ready_o     = !fifo_full;
   assign bus.blk_done_o      = done;
   assign bus.blk_done_mask_o = dec;
   assign bus.outstanding_o   = fifo_level;
   assign bus.err_o           = err_q;

endmodule

// File: tb/tb_done_tracker.sv
// Directed scenarios followed by random traffic, checked against a queue-based completion model.
module tb_done_tracker;
   import done_tracker_pkg::*;

   localparam int NS = 2;
   localparam int MO = 4;

   logic clk = 1'b0;
   logic rst_n;
   logic clr;

   always #5 clk = ~clk;

   done_tracker_if #(.NUM_STREAMS(NS), .MAX_OUTSTANDING(MO)) bus ();

   done_tracker #(.NUM_STREAMS(NS), .MAX_OUTSTANDING(MO)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .clr_i  (clr),
      .bus    (bus)
   );

   int    checks    = 0;
   int    failures  = 0;
   int    done_seen = 0;
   string phase     = "init";

   logic [NS-1:0] q_mask [$];
   int            m_cnt [NS];
   bit            m_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s.%s observed=%0h expected=%0h", phase, tag, obs, exp);
      end
   endtask

   function automatic bit m_done();
      if (q_mask.size() == 0) return 1'b0;
      for (int n = 0; n < NS; n++) begin
         if (q_mask[0][n] && m_cnt[n] == 0) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic m_reset();
      q_mask.delete();
      for (int n = 0; n < NS; n++) m_cnt[n] = 0;
      m_err = 1'b0;
   endtask

   task automatic m_step(input bit r, input bit c, input bit s,
                         input logic [NS-1:0] m, input logic [NS-1:0] l);
      bit            d;
      bit            was_full;
      bit            dec;
      logic [NS-1:0] hd;
      if (!r || c) begin
         m_reset();
         return;
      end
      d        = m_done();
      hd       = d ? q_mask[0] : '0;
      was_full = (q_mask.size() >= MO);
      for (int n = 0; n < NS; n++) begin
         dec = hd[n];
         if (l[n]) begin
            if (m_cnt[n] == MO && !dec) m_err = 1'b1;
            else m_cnt[n]++;
         end
         if (dec) m_cnt[n]--;
      end
      if (d) void'(q_mask.pop_front());
      if (s) begin
         if (was_full) m_err = 1'b1;
         else q_mask.push_back(m);
      end
   endtask

   task automatic check_all();
      bit            d;
      logic [NS-1:0] em;
      d  = m_done();
      em = d ? q_mask[0] : '0;
      check("done", 32'(bus.blk_done_o), 32'(d));
      check("mask", 32'(bus.blk_done_mask_o), 32'(em));
      check("ready", 32'(bus.blk_ready_o), 32'(q_mask.size() < MO));
      check("outstanding", 32'(bus.outstanding_o), 32'(q_mask.size()));
      check("err", 32'(bus.err_o), 32'(m_err));
   endtask

   // One clock cycle: apply inputs, compare outputs with the model, advance both.
   task automatic cyc(input bit r, input bit c, input bit s,
                      input logic [NS-1:0] m, input logic [NS-1:0] l);
      rst_n           = r;
      clr             = c;
      bus.blk_start_i = s;
      bus.blk_mask_i  = m;
      bus.last_hs_i   = l;
      check_all();
      if (bus.blk_done_o) done_seen++;
      m_step(r, c, s, m, l);
      @(posedge clk);
      #1;
   endtask

   task automatic step(input bit s, input logic [NS-1:0] m, input logic [NS-1:0] l);
      cyc(1'b1, 1'b0, s, m, l);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0);
   endtask

   task automatic scen_basic();
      step(1'b1, 2'b11, 2'b00);          // cycle 0
      idle(2);                           // cycles 1,2
      step(1'b0, 2'b00, 2'b01);          // cycle 3
      idle(1);                           // cycle 4
      check("c5_done", 32'(bus.blk_done_o), 32'd0);
      check("c5_outstanding", 32'(bus.outstanding_o), 32'd1);
      step(1'b0, 2'b00, 2'b10);          // cycle 5
      check("c6_done", 32'(bus.blk_done_o), 32'd1);
      check("c6_mask", 32'(bus.blk_done_mask_o), 32'd3);
      idle(1);                           // cycle 6
      check("c7_done", 32'(bus.blk_done_o), 32'd0);
      check("c7_outstanding", 32'(bus.outstanding_o), 32'd0);
   endtask

   initial begin
      logic [NS-1:0] rm;
      logic [NS-1:0] rl;
      rst_n           = 1'b0;
      clr             = 1'b0;
      bus.blk_start_i = 1'b0;
      bus.blk_mask_i  = '0;
      bus.last_hs_i   = '0;
      m_reset();
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;

      phase = "reset";
      check("done", 32'(bus.blk_done_o), 32'd0);
      check("mask", 32'(bus.blk_done_mask_o), 32'd0);
      check("ready", 32'(bus.blk_ready_o), 32'd1);
      check("outstanding", 32'(bus.outstanding_o), 32'd0);
      check("err", 32'(bus.err_o), 32'd0);

      phase = "split_lasts";
      scen_basic();

      phase = "joint_lasts";
      step(1'b1, 2'b11, 2'b00);
      idle(3);
      step(1'b0, 2'b00, 2'b11);
      check("done", 32'(bus.blk_done_o), 32'd1);
      idle(1);

      phase = "zero_mask";
      step(1'b1, 2'b00, 2'b00);
      check("done", 32'(bus.blk_done_o), 32'd1);
      check("mask", 32'(bus.blk_done_mask_o), 32'd0);
      idle(1);

      phase = "full";
      step(1'b1, 2'b11, 2'b00);
      step(1'b1, 2'b01, 2'b00);
      step(1'b1, 2'b10, 2'b00);
      step(1'b1, 2'b11, 2'b00);
      check("ready_full", 32'(bus.blk_ready_o), 32'd0);
      check("outstanding_full", 32'(bus.outstanding_o), 32'd4);
      step(1'b1, 2'b01, 2'b00);
      check("err_drop", 32'(bus.err_o), 32'd1);
      done_seen = 0;
      step(1'b0, 2'b00, 2'b10);
      step(1'b0, 2'b00, 2'b10);
      step(1'b0, 2'b00, 2'b10);
      step(1'b0, 2'b00, 2'b01);
      step(1'b0, 2'b00, 2'b01);
      step(1'b0, 2'b00, 2'b01);
      idle(3);
      check("done_count", 32'(done_seen), 32'd4);
      cyc(1'b1, 1'b1, 1'b0, '0, '0);
      check("err_clr", 32'(bus.err_o), 32'd0);

      phase = "early_lasts";
      for (int i = 0; i < 4; i++) step(1'b0, 2'b00, 2'b01);
      check("err_pre", 32'(bus.err_o), 32'd0);
      step(1'b0, 2'b00, 2'b01);
      check("err_ovf", 32'(bus.err_o), 32'd1);
      done_seen = 0;
      for (int i = 0; i < 4; i++) step(1'b1, 2'b01, 2'b00);
      idle(2);
      check("done_count", 32'(done_seen), 32'd4);
      cyc(1'b1, 1'b1, 1'b0, '0, '0);

      phase = "same_cycle";
      step(1'b1, 2'b01, 2'b00);
      step(1'b1, 2'b01, 2'b00);
      step(1'b0, 2'b00, 2'b01);
      check("done_b0", 32'(bus.blk_done_o), 32'd1);
      step(1'b0, 2'b00, 2'b01);
      check("done_b1", 32'(bus.blk_done_o), 32'd1);
      idle(1);
      check("outstanding", 32'(bus.outstanding_o), 32'd0);

      phase = "mid_reset";
      step(1'b1, 2'b11, 2'b00);
      step(1'b1, 2'b11, 2'b00);
      step(1'b1, 2'b11, 2'b01);
      cyc(1'b0, 1'b0, 1'b0, '0, '0);
      check("done", 32'(bus.blk_done_o), 32'd0);
      check("mask", 32'(bus.blk_done_mask_o), 32'd0);
      check("ready", 32'(bus.blk_ready_o), 32'd1);
      check("outstanding", 32'(bus.outstanding_o), 32'd0);
      check("err", 32'(bus.err_o), 32'd0);
      phase = "after_reset";
      scen_basic();

      phase = "random";
      for (int i = 0; i < 3000; i++) begin
         rm = NS'($urandom);
         for (int n = 0; n < NS; n++) rl[n] = ($urandom_range(0, 3) == 0);
         cyc(($urandom_range(0, 499) != 0), ($urandom_range(0, 149) == 0),
             ($urandom_range(0, 2) == 0), rm, rl);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
